// File: rtl/mem_bank_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bank_ctrl
// Single-bank SRAM controller placed behind the multi-master memory arbiter.
// It accepts the arbiter's slave-side request/grant/response handshake and
// drives one synchronous single-port SRAM macro with fixed read latency.
// It decodes the bank-local word address, applies byte strobes, tracks the
// read pipeline, returns read data with a one-cycle valid pulse and flags
// out-of-range accesses.
//
// Optional feature: define MEM_BANK_CTRL_PERF_EN to build the saturating
// read/write/error performance counters. Without it the counter outputs are
// tied to zero, perf_clr is ignored and no counter flops exist.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   s_req/s_wr      request and direction (1 = write)
//   s_addr          byte address
//   s_wdata/s_strb  write data and byte strobes
//   s_gnt           combinational grant, same cycle as the request in IDLE
//   s_rdata         registered read data, held between responses
//   s_rvalid        one-cycle read-data-valid pulse
//   s_err           out-of-range pulse (with s_gnt for writes, s_rvalid for reads)
//   sram_*          SRAM macro interface; all zero whenever sram_ce is low
//   perf_clr        synchronous clear of the performance counters
//   perf_*_cnt      granted-read / granted-write / error-pulse counters
//
// FSM states
//   state   | meaning
//   IDLE    | accepting requests; writes complete here in the grant cycle
//   RD_WAIT | waiting for the SRAM read latency, requests ignored
//   RD_RESP | presenting s_rvalid (and s_err for out-of-range) for one cycle
// -----------------------------------------------------------------------------
module mem_bank_ctrl #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 128,
  parameter int unsigned           DEPTH        = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int unsigned           READ_LATENCY = 1,
  localparam int unsigned          AW           = $clog2(DEPTH),
  localparam int unsigned          SW           = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_req,
  input  logic                  s_wr,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [SW-1:0]         s_strb,
  output logic                  s_gnt,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rvalid,
  output logic                  s_err,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [AW-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic [SW-1:0]         sram_bwe,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic                  perf_clr,
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_err_cnt
);

  localparam int unsigned OFF_BITS = $clog2(SW);
  localparam int unsigned CW       = 3;

  // One extra bit so that BASE_ADDR + bank size cannot wrap in the compare.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(DEPTH * SW);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        lat_cnt_q, lat_cnt_d;
  logic                 oor_q, oor_d;
  logic                 capture;

  logic                 in_range;
  logic [ADDR_WIDTH-1:0] addr_off;
  logic [AW-1:0]        word_addr;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  always_comb begin
    in_range  = ({1'b0, s_addr} >= BASE_EXT) && ({1'b0, s_addr} < LIMIT_EXT);
    addr_off  = s_addr - BASE_ADDR;
    word_addr = AW'(addr_off >> OFF_BITS);
  end

  // ---------------------------------------------------------------------------
  // State register, latency counter, range flag and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      oor_q     <= oor_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rdata <= '0;
    end else if (capture) begin
      // Out-of-range reads never touched the SRAM, so return zero.
      s_rdata <= oor_q ? '0 : sram_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    oor_d      = oor_q;
    capture    = 1'b0;
    s_gnt      = 1'b0;
    s_rvalid   = 1'b0;
    s_err      = 1'b0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_bwe   = '0;

    unique case (state_q)
      IDLE: begin
        // Grant is combinational; gate with rst so nothing leaks out while
        // reset is held.
        if (s_req && !rst) begin
          s_gnt = 1'b1;
          if (s_wr) begin
            if (in_range) begin
              sram_ce    = 1'b1;
              sram_we    = 1'b1;
              sram_addr  = word_addr;
              sram_wdata = s_wdata;
              sram_bwe   = s_strb;
            end else begin
              s_err = 1'b1;
            end
          end else begin
            if (in_range) begin
              sram_ce   = 1'b1;
              sram_addr = word_addr;
            end
            oor_d     = !in_range;
            lat_cnt_d = CW'(READ_LATENCY);
            state_d   = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        // Counter holds READ_LATENCY on entry; the data is on sram_rdata in
        // the cycle where it reaches 1.
        lat_cnt_d = lat_cnt_q - CW'(1);
        if (lat_cnt_q == CW'(1)) begin
          capture = 1'b1;
          state_d = RD_RESP;
        end
      end

      RD_RESP: begin
        s_rvalid = 1'b1;
        s_err    = oor_q;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef MEM_BANK_CTRL_PERF_EN
  logic rd_inc, wr_inc, err_inc;

  always_comb begin
    rd_inc  = s_gnt && !s_wr;
    wr_inc  = s_gnt && s_wr;
    err_inc = s_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_err_cnt <= '0;
    end else if (perf_clr) begin
      perf_rd_cnt  <= '0;
      perf_wr_cnt  <= '0;
      perf_err_cnt <= '0;
    end else begin
      if (rd_inc && (perf_rd_cnt != 32'hFFFF_FFFF)) begin
        perf_rd_cnt <= perf_rd_cnt + 32'd1;
      end
      if (wr_inc && (perf_wr_cnt != 32'hFFFF_FFFF)) begin
        perf_wr_cnt <= perf_wr_cnt + 32'd1;
      end
      if (err_inc && (perf_err_cnt != 32'hFFFF_FFFF)) begin
        perf_err_cnt <= perf_err_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_perf_clr;

  assign unused_perf_clr = perf_clr;
  assign perf_rd_cnt     = '0;
  assign perf_wr_cnt     = '0;
  assign perf_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bank_ctrl
// Directed plus randomized bench for mem_bank_ctrl with READ_LATENCY=2 and a
// non-zero bank base. A behavioural SRAM with configurable latency sits on the
// macro side; expected read data comes from a separate word array updated with
// byte-strobe arithmetic. Counter checks follow MEM_BANK_CTRL_PERF_EN.
// -----------------------------------------------------------------------------
module tb_mem_bank_ctrl;

  localparam int unsigned          AW_T  = 32;
  localparam int unsigned          DW    = 128;
  localparam int unsigned          DEP   = 4096;
  localparam logic [31:0]          BASE  = 32'h0001_0000;
  localparam int unsigned          RL    = 2;
  localparam logic [31:0]          SPAN  = 32'h0001_0000;

  logic         clk;
  logic         rst;
  logic         s_req;
  logic         s_wr;
  logic [31:0]  s_addr;
  logic [127:0] s_wdata;
  logic [15:0]  s_strb;
  logic         s_gnt;
  logic [127:0] s_rdata;
  logic         s_rvalid;
  logic         s_err;
  logic         sram_ce;
  logic         sram_we;
  logic [11:0]  sram_addr;
  logic [127:0] sram_wdata;
  logic [15:0]  sram_bwe;
  logic [127:0] sram_rdata;
  logic         perf_clr;
  logic [31:0]  perf_rd_cnt;
  logic [31:0]  perf_wr_cnt;
  logic [31:0]  perf_err_cnt;

  int checks = 0;
  int errors = 0;

  // Expected-value model state
  logic [127:0] ref_mem [0:DEP-1];
  logic [127:0] last_rdata;
  int           exp_rd, exp_wr, exp_err;

  mem_bank_ctrl #(
    .ADDR_WIDTH  (AW_T),
    .DATA_WIDTH  (DW),
    .DEPTH       (DEP),
    .BASE_ADDR   (BASE),
    .READ_LATENCY(RL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_req       (s_req),
    .s_wr        (s_wr),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_strb      (s_strb),
    .s_gnt       (s_gnt),
    .s_rdata     (s_rdata),
    .s_rvalid    (s_rvalid),
    .s_err       (s_err),
    .sram_ce     (sram_ce),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_bwe    (sram_bwe),
    .sram_rdata  (sram_rdata),
    .perf_clr    (perf_clr),
    .perf_rd_cnt (perf_rd_cnt),
    .perf_wr_cnt (perf_wr_cnt),
    .perf_err_cnt(perf_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM macro: data appears RL cycles after a read ce; the
  // output carries junk in every other cycle.
  logic [127:0] sram_mem [0:DEP-1];
  logic [127:0] pipe [0:RL-1];
  bit           mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEP; i++) sram_mem[i] <= '0;
      mem_init_done <= 1'b1;
    end else if (sram_ce && sram_we) begin
      for (int b = 0; b < 16; b++)
        if (sram_bwe[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
    if (sram_ce && !sram_we) pipe[0] <= sram_mem[sram_addr];
    else                     pipe[0] <= {$urandom, $urandom, $urandom, $urandom};
    for (int i = RL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
  end

  assign sram_rdata = pipe[RL-1];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  function automatic int model_word(input logic [31:0] a);
    return int'((a - BASE) / 32'd16);
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] st);
    bit inr;
    int w;
    inr = model_in_range(a);
    w   = inr ? model_word(a) : 0;
    @(negedge clk);
    s_req = 1'b1; s_wr = 1'b1; s_addr = a; s_wdata = d; s_strb = st;
    #1;
    chk("wr_gnt", 128'(s_gnt), 128'(1'b1));
    chk("wr_ce", 128'(sram_ce), 128'(inr));
    chk("wr_we", 128'(sram_we), 128'(inr));
    chk("wr_err", 128'(s_err), 128'(!inr));
    chk("wr_addr", 128'(sram_addr), inr ? 128'(w) : 128'(0));
    chk("wr_bwe", 128'(sram_bwe), inr ? 128'(st) : 128'(0));
    chk("wr_wdata", sram_wdata, inr ? d : 128'(0));
    if (inr)
      for (int b = 0; b < 16; b++)
        if (st[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    exp_wr++;
    if (!inr) exp_err++;
    @(posedge clk);
    #1;
    s_req = 1'b0;
  endtask

  // s_req stays high until rvalid, so the wait loop also proves no re-grant.
  task automatic do_read(input logic [31:0] a);
    bit inr;
    int w;
    int n;
    bit got;
    inr = model_in_range(a);
    w   = inr ? model_word(a) : 0;
    @(negedge clk);
    s_req = 1'b1; s_wr = 1'b0; s_addr = a;
    s_wdata = {$urandom, $urandom, $urandom, $urandom}; s_strb = 16'(($urandom));
    #1;
    chk("rd_gnt", 128'(s_gnt), 128'(1'b1));
    chk("rd_ce", 128'(sram_ce), 128'(inr));
    chk("rd_we", 128'(sram_we), 128'(0));
    chk("rd_addr", 128'(sram_addr), inr ? 128'(w) : 128'(0));
    chk("rd_err_at_gnt", 128'(s_err), 128'(0));
    exp_rd++;
    n = 0;
    got = 1'b0;
    while (n < 12 && !got) begin
      @(negedge clk);
      #1;
      n++;
      if (s_rvalid) got = 1'b1;
      else begin
        chk("rd_wait_gnt", 128'(s_gnt), 128'(0));
        chk("rd_wait_ce", 128'(sram_ce), 128'(0));
      end
    end
    chk("rd_rvalid_seen", 128'(got), 128'(1'b1));
    chk("rd_latency", 128'(n), 128'(RL + 1));
    chk("rd_resp_gnt", 128'(s_gnt), 128'(0));
    chk("rd_rdata", s_rdata, inr ? ref_mem[w] : 128'(0));
    chk("rd_err", 128'(s_err), 128'(!inr));
    last_rdata = inr ? ref_mem[w] : 128'(0);
    if (!inr) exp_err++;
    s_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rd_pulse_one_cycle", 128'(s_rvalid), 128'(0));
    chk("rd_rdata_hold", s_rdata, last_rdata);
  endtask

  task automatic chk_perf(input string tag);
`ifdef MEM_BANK_CTRL_PERF_EN
    chk({tag, "_rd"}, 128'(perf_rd_cnt), 128'(exp_rd));
    chk({tag, "_wr"}, 128'(perf_wr_cnt), 128'(exp_wr));
    chk({tag, "_err"}, 128'(perf_err_cnt), 128'(exp_err));
`else
    chk({tag, "_rd_off"}, 128'(perf_rd_cnt), 128'(0));
    chk({tag, "_wr_off"}, 128'(perf_wr_cnt), 128'(0));
    chk({tag, "_err_off"}, 128'(perf_err_cnt), 128'(0));
`endif
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bit          seen;

    for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
    last_rdata = '0;
    exp_rd = 0; exp_wr = 0; exp_err = 0;

    // Reset with a request pending: nothing may leak out.
    rst = 1'b1; perf_clr = 1'b0;
    s_req = 1'b1; s_wr = 1'b1; s_addr = BASE; s_wdata = '1; s_strb = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 128'(s_gnt), 128'(0));
    chk("rst_ce", 128'(sram_ce), 128'(0));
    chk("rst_we", 128'(sram_we), 128'(0));
    chk("rst_bwe", 128'(sram_bwe), 128'(0));
    chk("rst_wdata", sram_wdata, 128'(0));
    chk("rst_addr", 128'(sram_addr), 128'(0));
    chk("rst_rvalid", 128'(s_rvalid), 128'(0));
    chk("rst_err", 128'(s_err), 128'(0));
    chk("rst_rdata", s_rdata, 128'(0));
    chk_perf("rst_perf");
    s_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Full write then read-back.
    do_write(BASE + 32'h10, {16{8'hA5}}, 16'hFFFF);
    do_read(BASE + 32'h10);

    // Partial write on top of a zeroed word.
    do_write(BASE + 32'h20, 128'h0, 16'hFFFF);
    do_write(BASE + 32'h20, 128'hFF, 16'h0001);
    do_write(BASE + 32'h20, {16{8'h77}}, 16'h0000);
    do_read(BASE + 32'h20);
    chk("partial_value", s_rdata, 128'hFF);

    // Bank edges and out-of-range on both sides.
    do_write(BASE + SPAN - 32'd1, {4{32'hDEAD_BEEF}}, 16'hF00F);
    do_read(BASE + SPAN - 32'd16);
    do_write(BASE, {4{32'h1234_5678}}, 16'hFFFF);
    do_read(BASE + 32'd3);
    do_read(BASE + SPAN);
    do_write(BASE + SPAN, {16{8'h5A}}, 16'hFFFF);
    do_read(BASE - 32'd16);
    do_write(BASE - 32'd1, {16{8'h3C}}, 16'hFFFF);

    chk_perf("perf_dir");
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1;
`ifdef MEM_BANK_CTRL_PERF_EN
    exp_rd = 0; exp_wr = 0; exp_err = 0;
`endif
    chk_perf("perf_clr");

    // Randomized traffic over a few hot words, the top word and both
    // out-of-range sides.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE + SPAN + 32'($urandom_range(0, 255));
      else if (r == 1) a = BASE - 32'd1 - 32'($urandom_range(0, 255));
      else if (r == 2) a = BASE + SPAN - 32'd1 - 32'($urandom_range(0, 15));
      else             a = BASE + (32'($urandom_range(0, 7)) << 4) + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        do_write(a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      else
        do_read(a);
    end
    chk_perf("perf_rand");

    // Reset while a read is in flight: response must be discarded.
    @(negedge clk);
    s_req = 1'b1; s_wr = 1'b0; s_addr = BASE + 32'h10;
    #1;
    chk("midrst_gnt", 128'(s_gnt), 128'(1'b1));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_gnt_off", 128'(s_gnt), 128'(0));
    chk("midrst_rvalid", 128'(s_rvalid), 128'(0));
    chk("midrst_ce", 128'(sram_ce), 128'(0));
    chk("midrst_rdata", s_rdata, 128'(0));
    chk("midrst_err", 128'(s_err), 128'(0));
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    chk_perf("midrst_perf");
    s_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (s_rvalid) seen = 1'b1;
    end
    chk("midrst_no_rvalid", 128'(seen), 128'(0));

    // Normal operation resumes after reset.
    do_read(BASE + 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
